// File: rtl/clken_nco_bank.sv
// clken_nco_bank
//   Bank of NUM_CLOCKS fractional clock-enable generators (NCOs) running on a
//   single system clock. Each channel adds its increment to a phase
//   accumulator every cycle. The registered carry-out, delayed by one more
//   register, becomes a one-cycle ce pulse. Channel increments can be
//   reprogrammed at run time over a valid/ready config port. A PLL-style
//   "locked" flag drops while the bank settles after reset or after a write.
//
// Ports
//   refclk     in   system clock, all logic on rising edge
//   rst_n      in   asynchronous active-low reset
//   cfg_valid  in   config write request
//   cfg_ready  out  config write can be accepted (registered, high only when locked)
//   cfg_chan   in   [3:0] target channel; indices >= NUM_CLOCKS are accepted and dropped
//   cfg_inc    in   [ACC_W-1:0] new phase increment
//   ce         out  [NUM_CLOCKS-1:0] one-cycle enable pulses
//   outclk     out  [NUM_CLOCKS-1:0] square wave per channel, only with CLKEN_NCO_OUTCLK_EN
//   locked     out  all channels running with their current config
//   dbg_state  out  [1:0] FSM state (0 RST, 1 SETTLE, 2 LOCKED) for checkers
//
// Optional feature: define CLKEN_NCO_OUTCLK_EN to build the outclk port. The
// port carries the registered accumulator MSB, forced to 0 while unlocked.

module clken_nco_bank #(
  parameter int          NUM_CLOCKS  = 2,
  parameter int          ACC_W       = 32,
  parameter logic [47:0] INC_DEFAULT = 48'd152709948,
  parameter int          LOCK_CYCLES = 16
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3:0]            cfg_chan,
  input  logic [ACC_W-1:0]      cfg_inc,
  output logic [NUM_CLOCKS-1:0] ce,
`ifdef CLKEN_NCO_OUTCLK_EN
  output logic [NUM_CLOCKS-1:0] outclk,
`endif
  output logic                  locked,
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RST    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [ACC_W-1:0]      acc [NUM_CLOCKS];
  logic [ACC_W-1:0]      inc [NUM_CLOCKS];
  logic [ACC_W:0]        sum [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0] carry;

  // Handshake: a write transfers on any rising edge where cfg_valid and
  // cfg_ready are both high. cfg_ready is a register that is high only in
  // LOCKED, so the requester must hold cfg_valid/cfg_chan/cfg_inc steady until
  // it sees ready. A write to an in-range channel (wr_hit) restarts that
  // channel and forces a relock. An out-of-range write completes with no effect.
  logic accept;
  logic wr_hit;

  assign accept    = cfg_valid & cfg_ready;
  assign wr_hit    = accept && (int'(cfg_chan) < NUM_CLOCKS);
  assign dbg_state = state;

  // Lock FSM. locked and cfg_ready are registered alongside the state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RST;
      cnt       <= '0;
      locked    <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      case (state)
        ST_RST: begin
          state <= ST_SETTLE;
          cnt   <= '0;
        end
        ST_SETTLE: begin
          if (cnt == CNT_LAST) begin
            state     <= ST_LOCKED;
            cnt       <= '0;
            locked    <= 1'b1;
            cfg_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (wr_hit) begin
            state     <= ST_SETTLE;
            cnt       <= '0;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
          end
        end
        default: begin
          state     <= ST_RST;
          cnt       <= '0;
          locked    <= 1'b0;
          cfg_ready <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
    end
  end

`ifdef CLKEN_NCO_OUTCLK_EN
  logic [NUM_CLOCKS-1:0] outclk_q;
  // Gating with the locked register keeps outclk at 0 on exactly the cycles
  // where locked reads 0.
  assign outclk = outclk_q & {NUM_CLOCKS{locked}};
`endif

  // Accumulators keep running in every state. Only ce is gated by LOCKED.
  // Because ce samples the carry register, a carry registered one edge
  // before a write still shows up on ce in the cycle after the write.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        acc[i] <= '0;
        inc[i] <= INC_DEFAULT[ACC_W-1:0];
      end
      carry <= '0;
      ce    <= '0;
`ifdef CLKEN_NCO_OUTCLK_EN
      outclk_q <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        if (wr_hit && (cfg_chan == 4'(i))) begin
          acc[i]   <= '0;
          inc[i]   <= cfg_inc;
          carry[i] <= 1'b0;
        end else begin
          {carry[i], acc[i]} <= sum[i];
        end
        ce[i] <= carry[i] & (state == ST_LOCKED);
`ifdef CLKEN_NCO_OUTCLK_EN
        outclk_q[i] <= acc[i][ACC_W-1];
`endif
      end
    end
  end

endmodule

// File: doc/clken_nco_bank.md
Name: clken_nco_bank

Overview:
- Parametrised, runtime-reconfigurable successor to the fixed two-output clock PLL wrapper.
- Generates NUM_CLOCKS fractional clock-enable streams from one system clock using per-channel phase accumulators (NCOs). A typical use is a 3.579 MHz sound-chip enable derived from the ~100 MHz system clock.
- Adds behaviour the fixed PLL does not have: per-channel frequency reprogramming over a valid/ready config port, and a settle/lock indication modelled on PLL "locked".
- Sits beside the PLL in sys/; consumers gate logic on ce[i] instead of using extra clock domains.

Parameters:
NUM_CLOCKS, 2, number of enable channels (1..16)
ACC_W, 32, phase accumulator and increment width (8..48)
INC_DEFAULT, 32'd152709948, reset increment for every channel (3.579138 MHz from 100.663284 MHz at ACC_W=32)
LOCK_CYCLES, 16, settle cycles before locked asserts (>=1)

Ports:
refclk  in  1  system clock; all logic on its rising edge
rst_n  in  1  reset, asynchronous assert, active-low
cfg_valid  in  1  config write request
cfg_ready  out  1  config write can be accepted
cfg_chan  in  4  target channel index
cfg_inc  in  ACC_W  new phase increment
ce  out  NUM_CLOCKS  one-cycle enable pulse per channel
locked  out  1  all channels running with current config

Behaviour:
- Reset (rst_n low, asynchronous):
  - acc[i]=0 and inc[i]=INC_DEFAULT[ACC_W-1:0].
  - ce=0, locked=0, cfg_ready=0.
  - FSM=RST and settle counter=0.
- NCO, every cycle, for each channel:
  - {carry, acc[i]} <= acc[i] + inc[i], computed in ACC_W+1 bits; acc wraps mod 2^ACC_W.
  - ce[i] is registered: ce[i] <= carry & (FSM==LOCKED). It goes high the cycle after the carry edge.
  - Mean ce rate = f_refclk * inc / 2^ACC_W.
  - inc=0: the channel is stopped and ce[i] never pulses.
  - inc=2^ACC_W-1: ce[i] is high on every cycle except 1 per 2^ACC_W.
- FSM states: RST, SETTLE, LOCKED.
  - RST: entered only via reset. Goes to SETTLE on the first clock edge after rst_n deasserts.
  - SETTLE: the counter increments each cycle; cfg_ready=0. Goes to LOCKED when counter==LOCK_CYCLES-1, clearing the counter.
  - LOCKED: locked=1 and cfg_ready=1.
- Accumulators run in all states except while reset is asserted. The ce gating above applies in every state.
- Config handshake: a write is accepted on an edge where cfg_valid & cfg_ready.
  - Edge k, cfg_chan < NUM_CLOCKS: inc[cfg_chan]=cfg_inc and acc[cfg_chan]=0, effective from k+1. FSM goes to SETTLE, so locked=0 and cfg_ready=0 from k+1. Other channels keep phase and increment.
  - cfg_chan >= NUM_CLOCKS: the write is accepted and ignored. No relock and no state change.
  - cfg_valid while cfg_ready=0: not accepted. The requester holds it until ready.
- Boundary: with locked=1, ce pulses already pipelined at the accept edge k are still visible at k+1 only if their carry occurred before k. From k+1, ce is 0 until relock.
- Reset mid-SETTLE or mid-write: everything returns to reset values immediately. Partially applied writes are discarded.
- LOCK_CYCLES=1: SETTLE lasts exactly one cycle.

Optional Feature:
- Macro: CLKEN_NCO_OUTCLK_EN
- Defined: adds port outclk [NUM_CLOCKS] out.
  - outclk[i] is registered acc[i][ACC_W-1]: an approximately 50%-duty square wave at the ce rate, for driving pins or debug probes.
  - Forced 0 while locked=0; reset value 0.
- Undefined: the port is absent and no extra registers are built.

Test Plan:
- ACC_W=8, INC_DEFAULT=64, LOCK_CYCLES=4: release reset -> locked rises on cycle 5 after release (1 RST + 4 SETTLE). ce[0] and ce[1] then pulse exactly every 4th cycle.
- ACC_W=8, write chan0 inc=96 while locked -> cfg_ready and locked drop next cycle for 4 cycles. After relock, ce[0] pattern repeats every 8 cycles with 3 pulses. ce[1] stays at period 4 with unchanged phase.
- Write cfg_chan=5 with NUM_CLOCKS=2 -> accepted in one cycle; locked stays 1 and no ce disturbance.
- Write inc=0 to chan1 -> ce[1] is never asserted for 1000 cycles; ce[0] is unaffected.
- Hold cfg_valid during SETTLE -> no acceptance until locked=1, then accepted on the first ready edge.
- Assert rst_n low mid-SETTLE -> ce, locked and cfg_ready are 0 asynchronously. After release, the full sequence restarts with inc=INC_DEFAULT.
- With CLKEN_NCO_OUTCLK_EN, ACC_W=8, inc=64 -> outclk[0] toggles every 2 cycles once locked.
